// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int unsigned BIN_W   = 14;
    localparam int unsigned N_DIG   = 4;
    localparam int unsigned MAX_VAL = 9999;
    localparam int unsigned SCR_W   = 4 * N_DIG;
    localparam int unsigned CNT_W   = $clog2(BIN_W);

    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_ADD    = 4'd3;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StConv = 2'b01
    } state_e;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble adjuster: adds 3 to any nibble of 5 or more before the shift.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [3:0] nib,
    output logic [3:0] adj
);

    always_comb begin
        adj = nib;
        if (nib >= ADJ_THRESH) begin
            adj = nib + ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one shift-add-3 step per clock, with
// registered digits that only change on completion so the display stays steady.
module bin_to_bcd_seq
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       dig_thou,
    output logic [3:0]       dig_hund,
    output logic [3:0]       dig_tens,
    output logic [3:0]       dig_ones
);

    localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(MAX_VAL);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    state_e             state;
    logic [BIN_W-1:0]   shift;
    logic [SCR_W-1:0]   scratch;
    logic [SCR_W-1:0]   scratch_adj;
    logic [SCR_W-1:0]   scratch_nxt;
    logic [BIN_W-1:0]   shift_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_pend;

    for (genvar g = 0; g < N_DIG; g++) begin : g_adj
        bcd_add3 u_add3 (
            .nib (scratch[4*g +: 4]),
            .adj (scratch_adj[4*g +: 4])
        );
    end

    // The top adjusted bit falls off the end; it is always 0 for in-range inputs.
    always_comb begin
        scratch_nxt = {scratch_adj[SCR_W-2:0], shift[BIN_W-1]};
        shift_nxt   = {shift[BIN_W-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= StIdle;
            shift    <= '0;
            scratch  <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            dig_thou <= 4'd0;
            dig_hund <= 4'd0;
            dig_tens <= 4'd0;
            dig_ones <= 4'd0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        shift    <= bin_in;
                        scratch  <= '0;
                        cnt      <= '0;
                        ovf_pend <= (bin_in > MAX_BIN);
                        busy     <= 1'b1;
                        state    <= StConv;
                    end
                end
                StConv: begin
                    scratch <= scratch_nxt;
                    shift   <= shift_nxt;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        if (ovf_pend) begin
                            dig_thou <= 4'd9;
                            dig_hund <= 4'd9;
                            dig_tens <= 4'd9;
                            dig_ones <= 4'd9;
                        end else begin
                            dig_thou <= scratch_nxt[15:12];
                            dig_hund <= scratch_nxt[11:8];
                            dig_tens <= scratch_nxt[7:4];
                            dig_ones <= scratch_nxt[3:0];
                        end
                        ovf   <= ovf_pend;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
